mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of the ALU (execute) stage and upstream of writeback.
- Takes the registered ALU result, rt operand and instruction word.
- Performs LB/LBU/LH/LHU/LW/SB/SH/SW against the word-wide mem_controller port. Sub-word stores use read-modify-write.
- Forwards a registered result to writeback and stalls upstream while a memory transaction is in flight.

Parameters:
CHECK_ALIGN, 1, 1: misaligned LH/LHU/SH/LW/SW raise addr_error and are suppressed; 0: offending low address bits are ignored.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  execute-stage outputs are a real instruction
in_insn  in  [0:31]  instruction word; opcode = bits [0:5]
in_alu_result  in  [0:31]  effective address (mem ops) or ALU result
in_rt_data  in  [0:31]  store data
stall  out  1  upstream must hold all in_* this cycle
mem_address  out  [0:31]  word-aligned address to mem_controller
mem_wren  out  1  write strobe to mem_controller
mem_data_in  out  [0:31]  write data to memory
mem_data_out  in  [0:31]  read data from memory; valid the cycle after its address is presented
wb_valid  out  1  wb_* holds a retired instruction
wb_insn  out  [0:31]  retired instruction word
wb_data  out  [0:31]  load result, or in_alu_result for all other instructions
addr_error  out  1  one-cycle pulse on a suppressed misaligned access

Behaviour:
- Reset (async, reset_n=0) forces the following immediately:
  - state=IDLE; stall=0; mem_wren=0; mem_address=0; mem_data_in=0
  - wb_valid=0; wb_insn=0; wb_data=0; addr_error=0
- A reset mid-transaction aborts it. No write is issued after reset asserts.
- Bit numbering is big-endian. Byte lane k = addr[30:31] occupies bits [8k:8k+7]. Halfword lane h = addr[30] occupies bits [16h:16h+15].
- States: IDLE, RD, RD_DATA, WR. stall = (state != IDLE).
- IDLE, accept rule: an instruction is accepted on any edge where state=IDLE and in_valid=1. When accepted, insn, address and rt data are captured into internal registers.
- Non-memory instruction accepted:
  - next edge: wb_valid=1, wb_insn=in_insn, wb_data=in_alu_result
  - latency 1, full throughput, state stays IDLE
- in_valid=0 in IDLE: wb_valid=0 on the next edge.
- Load (LB/LBU/LH/LHU/LW):
  - IDLE → RD: mem_address = {addr_q[0:29],2'b00}, mem_wren=0.
  - RD → RD_DATA: lane extracted from mem_data_out; LB/LH sign-extend, LBU/LHU zero-extend.
  - RD_DATA → IDLE: wb_valid=1 with the loaded wb_data.
  - wb_valid rises on the 3rd edge after the accepting edge.
- SW: IDLE → WR.
  - In WR: mem_wren=1, mem_address aligned, mem_data_in=rt_q.
  - WR → IDLE: wb_valid=1, wb_data=addr_q.
- SB/SH: IDLE → RD → RD_DATA → WR → IDLE.
  - The RD_DATA edge latches merge_q = mem_data_out with the selected lane replaced by the low byte/halfword of rt_q.
  - WR writes merge_q.
  - wb_valid rises on the 4th edge after acceptance.
- wb_valid is 0 on every edge where nothing retires, including while in RD/RD_DATA/WR before completion.
- Misaligned access (CHECK_ALIGN=1):
  - halfword with addr[31]=1, or word with addr[30:31]≠0
  - no memory access is made, state stays IDLE
  - next edge: addr_error=1 for one cycle and wb_valid=0
- mem_wren is high only in state WR. Exactly one write cycle per store.
- Inputs are sampled only at the accepting edge. Input changes while stall=1 are ignored.
- The cycle in which state returns to IDLE has stall=0, so a new instruction can be accepted on that edge. No bubble is required between back-to-back memory ops.

Decomposition:
- Shared package mips_mem_pkg:
  - opcode constants OP_LB=6'h20, OP_LH=6'h21, OP_LW=6'h23, OP_LBU=6'h24, OP_LHU=6'h25, OP_SB=6'h28, OP_SH=6'h29, OP_SW=6'h2B
  - state encoding
  - access-size enum {SZ_BYTE, SZ_HALF, SZ_WORD}
- One combinational sub-module, mem_lane_align:
  - inputs: size, signed flag, addr[30:31], word, store data
  - outputs: extracted load value and merged store word
  - reused by the future cache block.

Test Plan:
- Memory word 0x8002_0010 = 0x1234_5678 (pre-loaded via srec) → LW, addr 0x8002_0010: stall high 2 cycles; wb_data=0x1234_5678 on the 3rd edge after accept.
- Word = 0x80FF_0102 → LB, addr 0x8002_0011: wb_data=0xFFFF_FFFF. LBU at the same address: wb_data=0x0000_00FF. LH at 0x8002_0010: wb_data=0xFFFF_80FF.
- Word = 0x1122_3344, rt=0x0000_00AB → SB, addr 0x8002_0012: one mem_wren cycle writing 0x1122_AB44; subsequent LW returns 0x1122_AB44.
- LW at 0x8002_0012 with CHECK_ALIGN=1 → mem_wren=0 throughout, no RD state, addr_error pulses once, wb_valid=0. Same with CHECK_ALIGN=0 → reads the word at 0x8002_0010.
- Four back-to-back ADDU (alu results 1, 2, 3, 4) followed by SW → wb_data 1, 2, 3, 4 on consecutive edges with stall=0, then stall=1 for exactly one cycle for the SW.
- reset_n driven low during the RD_DATA state of an SH → mem_wren never asserts; the memory word is unchanged; all outputs read 0 while reset_n=0; a normal LW after release succeeds.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage and its lane helper.
// Opcodes, FSM states, access sizes and a small opcode decoder.
package mips_mem_pkg;

   localparam logic [0:5] OP_LB  = 6'h20;
   localparam logic [0:5] OP_LH  = 6'h21;
   localparam logic [0:5] OP_LW  = 6'h23;
   localparam logic [0:5] OP_LBU = 6'h24;
   localparam logic [0:5] OP_LHU = 6'h25;
   localparam logic [0:5] OP_SB  = 6'h28;
   localparam logic [0:5] OP_SH  = 6'h29;
   localparam logic [0:5] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_DATA,
      ST_WR
   } mem_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } access_size_e;

   typedef struct packed {
      logic         is_mem;
      logic         is_load;
      logic         is_signed;
      access_size_e size;
   } mem_op_t;

   function automatic mem_op_t decode_op(input logic [0:5] opcode);
      mem_op_t op;
      op = '{is_mem: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: SZ_WORD};
      case (opcode)
         OP_LB:   op = '{1'b1, 1'b1, 1'b1, SZ_BYTE};
         OP_LBU:  op = '{1'b1, 1'b1, 1'b0, SZ_BYTE};
         OP_LH:   op = '{1'b1, 1'b1, 1'b1, SZ_HALF};
         OP_LHU:  op = '{1'b1, 1'b1, 1'b0, SZ_HALF};
         OP_LW:   op = '{1'b1, 1'b1, 1'b0, SZ_WORD};
         OP_SB:   op = '{1'b1, 1'b0, 1'b0, SZ_BYTE};
         OP_SH:   op = '{1'b1, 1'b0, 1'b0, SZ_HALF};
         OP_SW:   op = '{1'b1, 1'b0, 1'b0, SZ_WORD};
         default: op = '{1'b0, 1'b0, 1'b0, SZ_WORD};
      endcase
      return op;
   endfunction

   // lane = addr[30:31]; lane[1] is the least significant address bit
   function automatic logic misaligned(input access_size_e size, input logic [0:1] lane);
      return ((size == SZ_HALF) && lane[1]) || ((size == SZ_WORD) && (lane != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Word-wide port between the memory stage and mem_controller.
interface mem_stage_if;
   logic [0:31] mem_address;
   logic        mem_wren;
   logic [0:31] mem_data_in;
   logic [0:31] mem_data_out;

   modport master (
      output mem_address,
      output mem_wren,
      output mem_data_in,
      input  mem_data_out
   );

   modport slave (
      input  mem_address,
      input  mem_wren,
      input  mem_data_in,
      output mem_data_out
   );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte/halfword lane extraction and store merge on a 32-bit word.
// Purely combinational so the cache block can share it.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  access_size_e size,
   input  logic         is_signed,
   input  logic [0:1]   lane,
   input  logic [0:31]  word,
   input  logic [0:31]  store_data,
   output logic [0:31]  load_val,
   output logic [0:31]  merge_word
);

   logic [4:0]  byte_base;
   logic [4:0]  half_base;
   logic [0:7]  byte_sel;
   logic [0:15] half_sel;

   // lane k lives at bits [8k:8k+7]; lane 0 is the most significant byte
   assign byte_base = {lane, 3'b000};
   assign half_base = {lane[0], 4'b0000};

   always_comb begin
      byte_sel   = word[byte_base +: 8];
      half_sel   = word[half_base +: 16];
      load_val   = word;
      merge_word = store_data;
      case (size)
         SZ_BYTE: begin
            load_val   = {{24{is_signed & byte_sel[0]}}, byte_sel};
            merge_word = word;
            merge_word[byte_base +: 8] = store_data[24:31];
         end
         SZ_HALF: begin
            load_val   = {{16{is_signed & half_sel[0]}}, half_sel};
            merge_word = word;
            merge_word[half_base +: 16] = store_data[16:31];
         end
         default: begin
            load_val   = word;
            merge_word = store_data;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: loads, stores (sub-word via read-modify-write),
// registered writeback and upstream stall while a transaction is in flight.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | accepting; non-memory ops retire straight through
// ST_RD      | aligned read address presented to memory
// ST_RD_DATA | read data valid; loads retire, sub-word stores merge
// ST_WR      | single write strobe cycle; store retires on exit
module mem_stage
   import mips_mem_pkg::*;
#(
   parameter bit CHECK_ALIGN = 1'b1
)
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [0:31] in_insn,
   input  logic [0:31] in_alu_result,
   input  logic [0:31] in_rt_data,
   output logic        stall,
   mem_stage_if.master bus,
   output logic        wb_valid,
   output logic [0:31] wb_insn,
   output logic [0:31] wb_data,
   output logic        addr_error
);

   mem_state_e  state;
   logic [0:31] insn_q;
   logic [0:31] addr_q;
   logic [0:31] rt_q;
   logic [0:31] op_insn;
   mem_op_t     op;
   logic [0:31] load_val;
   logic [0:31] merge_word;

   // one decoder: the incoming word while idle, the held word otherwise
   assign op_insn = (state == ST_IDLE) ? in_insn : insn_q;
   assign op      = decode_op(op_insn[0:5]);
   assign stall   = (state != ST_IDLE);

   mem_lane_align u_lane_align (
      .size       (op.size),
      .is_signed  (op.is_signed),
      .lane       (addr_q[30:31]),
      .word       (bus.mem_data_out),
      .store_data (rt_q),
      .load_val   (load_val),
      .merge_word (merge_word)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         insn_q          <= '0;
         addr_q          <= '0;
         rt_q            <= '0;
         bus.mem_address <= '0;
         bus.mem_wren    <= 1'b0;
         bus.mem_data_in <= '0;
         wb_valid        <= 1'b0;
         wb_insn         <= '0;
         wb_data         <= '0;
         addr_error      <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         addr_error   <= 1'b0;
         bus.mem_wren <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  insn_q <= in_insn;
                  addr_q <= in_alu_result;
                  rt_q   <= in_rt_data;
                  if (!op.is_mem) begin
                     wb_valid <= 1'b1;
                     wb_insn  <= in_insn;
                     wb_data  <= in_alu_result;
                  end else if (CHECK_ALIGN && misaligned(op.size, in_alu_result[30:31])) begin
                     addr_error <= 1'b1;
                  end else if (op.is_load || (op.size != SZ_WORD)) begin
                     state           <= ST_RD;
                     bus.mem_address <= {in_alu_result[0:29], 2'b00};
                  end else begin
                     state           <= ST_WR;
                     bus.mem_address <= {in_alu_result[0:29], 2'b00};
                     bus.mem_wren    <= 1'b1;
                     bus.mem_data_in <= in_rt_data;
                  end
               end
            end
            ST_RD: begin
               state <= ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (op.is_load) begin
                  state    <= ST_IDLE;
                  wb_valid <= 1'b1;
                  wb_insn  <= insn_q;
                  wb_data  <= load_val;
               end else begin
                  // mem_data_in doubles as the merged read-modify-write word
                  state           <= ST_WR;
                  bus.mem_wren    <= 1'b1;
                  bus.mem_data_in <= merge_word;
               end
            end
            ST_WR: begin
               state    <= ST_IDLE;
               wb_valid <= 1'b1;
               wb_insn  <= insn_q;
               wb_data  <= addr_q;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
